// File: rtl/b10_serial_complementer.sv
// Serial N-digit BCD nines'/tens' complementer: one digit per clock, LSD first,
// framed by a soc/eoc handshake, with sticky flagging of non-BCD digit codes.
module b10_serial_complementer #(
    parameter int N = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           soc,
    input  logic           mode,
    input  logic [4*N-1:0] x_in,
    output logic [4*N-1:0] z_out,
    output logic           eoc,
    output logic           err
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg;
    logic [4*N-1:0] operand_reg;
    logic [4*N-1:0] result_reg;
    logic [CW-1:0]  counter_reg;
    logic           carry_reg;

    logic [3:0]     digit [N];
    logic [3:0]     cur_digit;
    logic [4:0]     sum_raw;
    logic           invalid;
    logic [3:0]     emit;
    logic           carry_next;
    logic [4*N-1:0] result_next;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_digit
            assign digit[gi] = operand_reg[4*gi +: 4];
            // Only the digit slot selected by the counter takes the new value.
            assign result_next[4*gi +: 4] = (counter_reg == CW'(gi)) ? emit
                                                                      : result_reg[4*gi +: 4];
        end
    endgenerate

    assign cur_digit = digit[counter_reg];
    assign invalid   = (cur_digit > 4'd9);
    assign sum_raw   = {1'b0, 4'd9 - cur_digit} + {4'd0, carry_reg};

    always_comb begin
        emit       = 4'd0;
        carry_next = 1'b0;
        if (!invalid) begin
            if (sum_raw == 5'd10) begin
                emit       = 4'd0;
                carry_next = 1'b1;
            end else begin
                emit       = sum_raw[3:0];
                carry_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            operand_reg <= '0;
            result_reg  <= '0;
            counter_reg <= '0;
            carry_reg   <= 1'b0;
            z_out       <= '0;
            eoc         <= 1'b1;
            err         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    eoc <= 1'b1;
                    if (soc) begin
                        operand_reg <= x_in;
                        carry_reg   <= mode;
                        counter_reg <= '0;
                        err         <= 1'b0;
                        eoc         <= 1'b0;
                        state_reg   <= BUSY;
                    end
                end
                BUSY: begin
                    result_reg  <= result_next;
                    carry_reg   <= carry_next;
                    counter_reg <= counter_reg + 1'b1;
                    if (invalid) begin
                        err <= 1'b1;
                    end
                    // Carry out of the last digit is deliberately dropped.
                    if (counter_reg == CW'(N - 1)) begin
                        z_out       <= result_next;
                        eoc         <= 1'b1;
                        counter_reg <= '0;
                        state_reg   <= DONE;
                    end
                end
                DONE: begin
                    eoc <= 1'b1;
                    if (!soc) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    eoc       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_b10_serial_complementer.sv
// Directed bench for b10_serial_complementer (N = 4): complement results,
// error flag, handshake holding, operand capture and asynchronous reset.
module tb_b10_serial_complementer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        soc   = 1'b0;
    logic        mode  = 1'b0;
    logic [15:0] x_in  = 16'h0;
    logic [15:0] z_out;
    logic        eoc;
    logic        err;

    int checks = 0;
    int errors = 0;

    b10_serial_complementer #(.N(4)) dut (
        .clock (clock),
        .reset (reset),
        .soc   (soc),
        .mode  (mode),
        .x_in  (x_in),
        .z_out (z_out),
        .eoc   (eoc),
        .err   (err)
    );

    always #5 clock = ~clock;

    // Returns to IDLE, issues one start, scrambles inputs after the start edge,
    // and counts edges (start edge included) until eoc is seen high.
    task automatic run_conv(input logic [15:0] x, input logic m, output int edges);
        @(negedge clock);
        soc = 1'b0;
        @(negedge clock);
        x_in = x;
        mode = m;
        soc  = 1'b1;
        @(posedge clock);
        #1;
        soc   = 1'b0;
        x_in  = x ^ 16'h5A5A;
        mode  = ~m;
        edges = 1;
        while (eoc !== 1'b1 && edges < 20) begin
            @(posedge clock);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if ({eoc, err, z_out} !== {1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_values: eoc=%b err=%b z=%h, want eoc=1 err=0 z=0000", eoc, err, z_out);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if ({eoc, err, z_out} !== {1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL idle_after_reset: eoc=%b err=%b z=%h, want eoc=1 err=0 z=0000", eoc, err, z_out);
        end
    endtask

    task automatic test_nines();
        int edges;
        run_conv(16'h1234, 1'b0, edges);
        checks++;
        if (edges != 5) begin
            errors++;
            $display("FAIL nines_latency: edges=%0d, want 5", edges);
        end
        checks++;
        if ({err, z_out} !== {1'b0, 16'h8765}) begin
            errors++;
            $display("FAIL nines_1234: z=%h err=%b, want z=8765 err=0", z_out, err);
        end
        run_conv(16'h0000, 1'b0, edges);
        checks++;
        if (z_out !== 16'h9999 || edges != 5) begin
            errors++;
            $display("FAIL nines_0000: z=%h edges=%0d, want z=9999 edges=5", z_out, edges);
        end
    endtask

    task automatic test_tens();
        int edges;
        run_conv(16'h1200, 1'b1, edges);
        checks++;
        if ({err, z_out} !== {1'b0, 16'h8800} || edges != 5) begin
            errors++;
            $display("FAIL tens_1200: z=%h err=%b edges=%0d, want z=8800 err=0 edges=5", z_out, err, edges);
        end
        run_conv(16'h0000, 1'b1, edges);
        checks++;
        if (z_out !== 16'h0000 || edges != 5) begin
            errors++;
            $display("FAIL tens_0000: z=%h edges=%0d, want z=0000 edges=5", z_out, edges);
        end
    endtask

    task automatic test_invalid();
        int edges;
        run_conv(16'h12A4, 1'b0, edges);
        checks++;
        if ({err, z_out} !== {1'b1, 16'h8705}) begin
            errors++;
            $display("FAIL invalid_12A4: z=%h err=%b, want z=8705 err=1", z_out, err);
        end
        run_conv(16'h0001, 1'b1, edges);
        checks++;
        if ({err, z_out} !== {1'b0, 16'h9999}) begin
            errors++;
            $display("FAIL err_clear_0001: z=%h err=%b, want z=9999 err=0", z_out, err);
        end
    endtask

    task automatic test_handshake_hold();
        int edges;
        int bad = 0;
        run_conv(16'h1234, 1'b0, edges);
        soc  = 1'b1;
        x_in = 16'h0000;
        mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            if (eoc !== 1'b1 || z_out !== 16'h8765) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL done_hold: %0d bad cycles (last eoc=%b z=%h), want eoc=1 z=8765", bad, eoc, z_out);
        end
        @(negedge clock);
        soc = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (eoc !== 1'b1) begin
            errors++;
            $display("FAIL back_to_idle: eoc=%b, want 1", eoc);
        end
        @(negedge clock);
        soc = 1'b1;
        @(posedge clock);
        #1;
        soc = 1'b0;
        checks++;
        if (eoc !== 1'b0 || z_out !== 16'h8765) begin
            errors++;
            $display("FAIL restart_edge: eoc=%b z=%h, want eoc=0 z=8765", eoc, z_out);
        end
        edges = 1;
        while (eoc !== 1'b1 && edges < 20) begin
            @(posedge clock);
            #1;
            edges++;
        end
        checks++;
        if (z_out !== 16'h9999 || edges != 5) begin
            errors++;
            $display("FAIL restart_result: z=%h edges=%0d, want z=9999 edges=5", z_out, edges);
        end
    endtask

    task automatic test_stability();
        int edges;
        int bad = 0;
        @(negedge clock);
        soc = 1'b0;
        @(negedge clock);
        x_in = 16'h0009;
        mode = 1'b1;
        soc  = 1'b1;
        @(posedge clock);
        #1;
        soc = 1'b1;
        edges = 1;
        while (eoc !== 1'b1 && edges < 20) begin
            x_in = 16'hFFFF - 16'(edges);
            mode = edges[0];
            if (z_out !== 16'h9999) bad++;
            @(posedge clock);
            #1;
            edges++;
        end
        soc = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL z_hold_busy: %0d cycles z changed, want z=9999 throughout", bad);
        end
        checks++;
        if ({err, z_out} !== {1'b0, 16'h9991} || edges != 5) begin
            errors++;
            $display("FAIL captured_operand: z=%h err=%b edges=%0d, want z=9991 err=0 edges=5", z_out, err, edges);
        end
    endtask

    task automatic test_reset_mid_busy();
        int edges;
        @(negedge clock);
        soc = 1'b0;
        @(negedge clock);
        x_in = 16'h12A4;
        mode = 1'b0;
        soc  = 1'b1;
        @(posedge clock);
        #1;
        soc = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        checks++;
        if (eoc !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_state: eoc=%b err=%b, want eoc=0 err=1", eoc, err);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({eoc, err, z_out} !== {1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL async_reset: eoc=%b err=%b z=%h, want eoc=1 err=0 z=0000", eoc, err, z_out);
        end
        @(negedge clock);
        reset = 1'b0;
        run_conv(16'h0009, 1'b1, edges);
        checks++;
        if ({err, z_out} !== {1'b0, 16'h9991} || edges != 5) begin
            errors++;
            $display("FAIL after_reset_conv: z=%h err=%b edges=%0d, want z=9991 err=0 edges=5", z_out, err, edges);
        end
    endtask

    initial begin
        test_reset();
        test_nines();
        test_tens();
        test_invalid();
        test_handshake_hold();
        test_stability();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
